// File: rtl/nios_security_cpu_debug_pkg.sv
// Shared types and constants for the Nios II debug-memory controller.
// Holds the controller state encoding and the jdo field positions.
package nios_security_cpu_debug_pkg;

    localparam int DATA_W        = 32;
    localparam int BE_W          = DATA_W / 8;
    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RDFLAG    = 34;
    localparam int JDO_WDATA_LSB = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        J_RD  = 2'd1,
        J_RDD = 2'd2,
        C_RD  = 2'd3
    } state_t;

endpackage

// File: rtl/nios_security_cpu_debug_ram.sv
// Single-port synchronous debug RAM with byte enables and one-cycle read latency.
// Read-during-write returns the old word.
module nios_security_cpu_debug_ram
    import nios_security_cpu_debug_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset on purpose so it maps onto block RAM; contents start undefined.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/nios_security_cpu_debug_mem.sv
// Debug-memory controller: JTAG address/read/write commands and a CPU Avalon-MM port
// sharing one private RAM, with JTAG strobes taking priority.
module nios_security_cpu_debug_mem
    import nios_security_cpu_debug_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [BE_W-1:0]   avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest
);

    state_t            state, next_state;
    logic [ADDR_W:0]   mon_a_reg;
    logic [ADDR_W:0]   load_addr;
    logic [ADDR_W:0]   rd_addr;
    logic [DATA_W-1:0] jdo_wdata;
    logic              any_strobe;
    logic              rd_req;
    logic              wr_req;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [BE_W-1:0]   ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    // Bits of jdo outside the address and data fields carry nothing for this block.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RDFLAG+1], jdo[JDO_WDATA_LSB-1:0]};

    assign load_addr  = jdo[JDO_ADDR_LSB +: ADDR_W+1];
    assign jdo_wdata  = jdo[JDO_WDATA_LSB +: DATA_W];
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    // Load has priority over read-next, which has priority over write, if strobes collide.
    assign rd_req  = (take_action_ocimem_a & jdo[JDO_RDFLAG]) |
                     (!take_action_ocimem_a & take_no_action_ocimem_a);
    assign wr_req  = !take_action_ocimem_a & !take_no_action_ocimem_a & take_action_ocimem_b;
    assign rd_addr = take_action_ocimem_a ? load_addr : mon_a_reg;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a value held (no latch).
    always_comb begin
        next_state      = state;
        ram_we          = 1'b0;
        ram_addr        = avs_address;
        ram_be          = avs_byteenable;
        ram_wdata       = avs_writedata;
        avs_waitrequest = 1'b1;
        case (state)
            IDLE: begin
                if (any_strobe) begin
                    if (rd_req && !rd_addr[ADDR_W]) begin
                        next_state = J_RD;
                    end else if (wr_req && !mon_a_reg[ADDR_W]) begin
                        ram_we    = 1'b1;
                        ram_addr  = mon_a_reg[ADDR_W-1:0];
                        ram_be    = '1;
                        ram_wdata = jdo_wdata;
                    end
                end else if (avs_write) begin
                    ram_we          = 1'b1;
                    avs_waitrequest = 1'b0;
                end else if (avs_read) begin
                    next_state = C_RD;
                end
            end
            J_RD: begin
                ram_addr   = mon_a_reg[ADDR_W-1:0];
                next_state = J_RDD;
            end
            J_RDD: next_state = IDLE;
            C_RD: begin
                avs_waitrequest = !avs_read;
                next_state      = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (reset) begin
            next_state      = IDLE;
            ram_we          = 1'b0;
            avs_waitrequest = 1'b1;
        end
    end

    assign avs_readdata = (state == C_RD) ? ram_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            mon_a_reg     <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            if (state == J_RDD) begin
                MonDReg       <= ram_q;
                monitor_ready <= 1'b1;
                mon_a_reg     <= mon_a_reg + 1'b1;
            end
            if (any_strobe) begin
                if (state != IDLE) begin
                    // Busy: the command is dropped but reported as a failed completion.
                    monitor_ready <= 1'b1;
                    monitor_error <= 1'b1;
                end else begin
                    monitor_ready <= 1'b0;
                    monitor_error <= 1'b0;
                    if (take_action_ocimem_a) mon_a_reg <= load_addr;
                    if (rd_req) begin
                        if (rd_addr[ADDR_W]) begin
                            monitor_ready <= 1'b1;
                            monitor_error <= 1'b1;
                            mon_a_reg     <= rd_addr + 1'b1;
                        end
                    end else if (wr_req) begin
                        monitor_ready <= 1'b1;
                        monitor_error <= mon_a_reg[ADDR_W];
                        mon_a_reg     <= mon_a_reg + 1'b1;
                    end else begin
                        monitor_ready <= 1'b1;
                    end
                end
            end
        end
    end

    nios_security_cpu_debug_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_nios_security_cpu_debug_mem.sv
// Directed bench for the debug-memory controller: a table of JTAG commands with
// hand-computed results, plus sequences for read timing, arbitration, CPU writes and reset.
module tb_nios_security_cpu_debug_mem;
    import nios_security_cpu_debug_pkg::*;

    localparam int ADDR_W = 8;

    typedef enum int {OP_LOAD, OP_NEXT, OP_WRITE} op_t;

    typedef struct {
        op_t         op;
        logic [8:0]  addr;
        logic        rdflag;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_dreg;
        logic        exp_ready;
        logic        exp_error;
        logic [8:0]  exp_areg;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [JDO_W-1:0]  jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [DATA_W-1:0] MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [BE_W-1:0]   avs_byteenable;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_waitrequest;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nios_security_cpu_debug_mem #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input op_t op, input logic [8:0] addr, input logic rd, input logic [31:0] wd);
        jdo = '0;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        case (op)
            OP_LOAD: begin
                jdo[JDO_ADDR_LSB +: 9] = addr;
                jdo[JDO_RDFLAG]        = rd;
                take_action_ocimem_a   = 1'b1;
            end
            OP_NEXT: take_no_action_ocimem_a = 1'b1;
            default: begin
                jdo[JDO_WDATA_LSB +: 32] = wd;
                take_action_ocimem_b     = 1'b1;
            end
        endcase
    endtask

    task automatic clear_strobes();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic jtag_status(input string tag, input logic [31:0] dreg, input logic rdy,
                               input logic err, input logic [8:0] areg);
        check({tag, " MonDReg"}, MonDReg, dreg);
        check({tag, " ready"}, {31'd0, monitor_ready}, {31'd0, rdy});
        check({tag, " error"}, {31'd0, monitor_error}, {31'd0, err});
        check({tag, " MonAReg"}, {23'd0, dut.mon_a_reg}, {23'd0, areg});
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        avs_address    = addr;
        avs_writedata  = data;
        avs_byteenable = be;
        avs_write      = 1'b1;
        #1;
        check("cpu write waitrequest", {31'd0, avs_waitrequest}, 32'd0);
        tick();
        avs_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] addr, output logic [31:0] data, output int cycles);
        avs_address = addr;
        avs_read    = 1'b1;
        cycles      = 0;
        #1;
        while (avs_waitrequest && cycles < 20) begin
            tick();
            cycles++;
        end
        data     = avs_readdata;
        tick();
        avs_read = 1'b0;
    endtask

    vec_t        vecs [13];
    logic [31:0] rdata;
    int          n;

    initial begin
        vecs[0]  = '{OP_LOAD,  9'h005, 1'b0, 32'h0,        1, 32'h0,        1'b1, 1'b0, 9'h005};
        vecs[1]  = '{OP_WRITE, 9'h000, 1'b0, 32'h12345678, 1, 32'h0,        1'b1, 1'b0, 9'h006};
        vecs[2]  = '{OP_WRITE, 9'h000, 1'b0, 32'h9ABCDEF0, 1, 32'h0,        1'b1, 1'b0, 9'h007};
        vecs[3]  = '{OP_LOAD,  9'h005, 1'b1, 32'h0,        3, 32'h12345678, 1'b1, 1'b0, 9'h006};
        vecs[4]  = '{OP_NEXT,  9'h000, 1'b0, 32'h0,        3, 32'h9ABCDEF0, 1'b1, 1'b0, 9'h007};
        vecs[5]  = '{OP_LOAD,  9'h0FF, 1'b0, 32'h0,        1, 32'h9ABCDEF0, 1'b1, 1'b0, 9'h0FF};
        vecs[6]  = '{OP_WRITE, 9'h000, 1'b0, 32'h0000000A, 1, 32'h9ABCDEF0, 1'b1, 1'b0, 9'h100};
        vecs[7]  = '{OP_WRITE, 9'h000, 1'b0, 32'h0000000B, 1, 32'h9ABCDEF0, 1'b1, 1'b1, 9'h101};
        vecs[8]  = '{OP_NEXT,  9'h000, 1'b0, 32'h0,        1, 32'h9ABCDEF0, 1'b1, 1'b1, 9'h102};
        vecs[9]  = '{OP_LOAD,  9'h1FF, 1'b0, 32'h0,        1, 32'h9ABCDEF0, 1'b1, 1'b0, 9'h1FF};
        vecs[10] = '{OP_WRITE, 9'h000, 1'b0, 32'h00000055, 1, 32'h9ABCDEF0, 1'b1, 1'b1, 9'h000};
        vecs[11] = '{OP_LOAD,  9'h0FF, 1'b1, 32'h0,        3, 32'h0000000A, 1'b1, 1'b0, 9'h100};
        vecs[12] = '{OP_LOAD,  9'h180, 1'b1, 32'h0,        1, 32'h0000000A, 1'b1, 1'b1, 9'h181};

        reset          = 1'b1;
        jdo            = '0;
        clear_strobes();
        avs_address    = '0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_byteenable = '0;
        tick();
        tick();
        check("reset waitrequest", {31'd0, avs_waitrequest}, 32'd1);
        check("reset readdata", avs_readdata, 32'h0);
        reset = 1'b0;
        jtag_status("reset", 32'h0, 1'b0, 1'b0, 9'h000);

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].addr, vecs[i].rdflag, vecs[i].wdata);
            tick();
            clear_strobes();
            for (int c = 1; c < vecs[i].lat; c++) tick();
            jtag_status($sformatf("v%0d", i), vecs[i].exp_dreg, vecs[i].exp_ready,
                        vecs[i].exp_error, vecs[i].exp_areg);
        end

        // Read latency: result appears only at cycle 3.
        issue(OP_LOAD, 9'h005, 1'b1, 32'h0);
        tick();
        clear_strobes();
        check("rd c1 ready", {31'd0, monitor_ready}, 32'd0);
        tick();
        check("rd c2 ready", {31'd0, monitor_ready}, 32'd0);
        tick();
        jtag_status("rd c3", 32'h12345678, 1'b1, 1'b0, 9'h006);

        // Strobe while busy is dropped and flagged; the running read still completes once.
        issue(OP_LOAD, 9'h006, 1'b1, 32'h0);
        tick();
        issue(OP_NEXT, 9'h000, 1'b0, 32'h0);
        tick();
        clear_strobes();
        check("busy drop ready", {31'd0, monitor_ready}, 32'd1);
        check("busy drop error", {31'd0, monitor_error}, 32'd1);
        tick();
        jtag_status("busy done", 32'h9ABCDEF0, 1'b1, 1'b1, 9'h007);

        // CPU read collides with a JTAG read strobe and waits for it.
        issue(OP_LOAD, 9'h005, 1'b0, 32'h0);
        tick();
        issue(OP_NEXT, 9'h000, 1'b0, 32'h0);
        avs_address = 8'd5;
        avs_read    = 1'b1;
        #1;
        check("arb c0 waitrequest", {31'd0, avs_waitrequest}, 32'd1);
        tick();
        clear_strobes();
        n = 1;
        while (avs_waitrequest && n < 20) begin
            tick();
            n++;
        end
        check("arb stall cycles", n, 32'd4);
        check("arb readdata", avs_readdata, 32'h12345678);
        check("arb jtag MonDReg", MonDReg, 32'h12345678);
        tick();
        avs_read = 1'b0;

        // Byte-enabled CPU write, then CPU read back with one-cycle latency.
        cpu_write(8'd7, 32'h0, 4'hF);
        cpu_write(8'd7, 32'hFFFFFFFF, 4'b0010);
        cpu_read(8'd7, rdata, n);
        check("cpu be readdata", rdata, 32'h0000FF00);
        check("cpu read latency", n, 32'd1);

        // Reset during J_RD aborts the read and restores reset values.
        issue(OP_LOAD, 9'h005, 1'b1, 32'h0);
        tick();
        clear_strobes();
        reset = 1'b1;
        #1;
        check("mid reset waitrequest", {31'd0, avs_waitrequest}, 32'd1);
        tick();
        reset = 1'b0;
        jtag_status("post reset", 32'h0, 1'b0, 1'b0, 9'h000);
        issue(OP_LOAD, 9'h005, 1'b1, 32'h0);
        tick();
        clear_strobes();
        tick();
        tick();
        jtag_status("after reset rd", 32'h12345678, 1'b1, 1'b0, 9'h006);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
